// File: rtl/m_sram16_pkg.sv
// Shared types and helpers for the 16-bit async SRAM Wishbone controller.
package m_sram16_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_ACK} state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  // Active-low {ub_n, lb_n} for one halfword phase; reads always enable both lanes.
  function automatic logic [1:0] lane_en_n(input logic we, input logic [1:0] sel_pair);
    return we ? ~sel_pair : 2'b00;
  endfunction

endpackage

// File: rtl/m_sram16_waitcnt.sv
// Loadable strobe-length down-counter; last is high once the count reaches zero.
module m_sram16_waitcnt
  import m_sram16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               dec,
  input  logic [PHASE_W-1:0] load_val,
  output logic               last
);

  logic [PHASE_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (load)                   cnt_q <= load_val;
    else if (dec && cnt_q != '0)     cnt_q <= cnt_q - PHASE_W'(1);
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/m_sram16_wbctrl.sv
// Wishbone classic slave splitting 32-bit accesses into two 16-bit async SRAM phases.
// Define M_SRAM16_SKIPHALF_EN to skip write phases whose byte-select pair is zero.
module m_sram16_wbctrl
  import m_sram16_pkg::*;
#(
  parameter int SRAMADRWIDTH = 16,
  parameter int WAITSTATES   = 1
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [SRAMADRWIDTH-1:0] ADR_I,
  input  logic [3:0]              SEL_I,
  input  logic [31:0]             DAT_I,
  output logic [31:0]             DAT_O,
  output logic                    ACK_O,
  output logic [SRAMADRWIDTH:0]   sram_a,
  output logic [15:0]             sram_d_o,
  output logic                    sram_d_oe,
  input  logic [15:0]             sram_d_i,
  output logic                    sram_cs_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic                    sram_lb_n,
  output logic                    sram_ub_n
);

`ifdef M_SRAM16_SKIPHALF_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam logic [PHASE_W-1:0] WS = PHASE_W'(WAITSTATES);

  state_e                  state_q, state_d;
  logic                    strb_q, strb_d;
  logic [SRAMADRWIDTH-1:0] adr_q, adr_n;
  wb_req_t                 req_q, req_n;
  logic                    accept;
  logic                    cnt_load, cnt_dec, cnt_last;
  logic                    in_phase, phase_hi, wr_stb;
  logic [1:0]              sel_pair, lane_n;

  assign accept = (state_q == S_IDLE) && CYC_I && STB_I;
  // Outputs are registered from next-state, so the accepting edge must see the live bus.
  assign adr_n  = accept ? ADR_I : adr_q;
  assign req_n  = accept ? wb_req_t'{we: WE_I, sel: SEL_I, dat: DAT_I} : req_q;

  m_sram16_waitcnt u_waitcnt (
    .clk      (CLK_I),
    .rst_n    (RST_I),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WS),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    strb_d   = strb_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        strb_d = 1'b0;
        if (SKIP_EN && WE_I && SEL_I[1:0] == 2'b00)
          state_d = (SEL_I[3:2] == 2'b00) ? S_ACK : S_HI;
        else
          state_d = S_LO;
      end
      S_LO: begin
        if (!strb_q) begin
          strb_d   = 1'b1;
          cnt_load = 1'b1;
        end else if (cnt_last) begin
          strb_d  = 1'b0;
          state_d = (SKIP_EN && req_q.we && req_q.sel[3:2] == 2'b00) ? S_ACK : S_HI;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_HI: begin
        if (!strb_q) begin
          strb_d   = 1'b1;
          cnt_load = 1'b1;
        end else if (cnt_last) begin
          strb_d  = 1'b0;
          state_d = S_ACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_ACK: begin
        strb_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !CYC_I) begin
      state_d  = S_IDLE;
      strb_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  assign in_phase = (state_d == S_LO) || (state_d == S_HI);
  assign phase_hi = (state_d == S_HI);
  assign sel_pair = phase_hi ? req_n.sel[3:2] : req_n.sel[1:0];
  assign lane_n   = lane_en_n(req_n.we, sel_pair);
  assign wr_stb   = in_phase && strb_d && req_n.we;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q   <= S_IDLE;
      strb_q    <= 1'b0;
      adr_q     <= '0;
      req_q     <= '0;
      ACK_O     <= 1'b0;
      DAT_O     <= '0;
      sram_a    <= '0;
      sram_d_o  <= '0;
      sram_d_oe <= 1'b0;
      sram_cs_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      adr_q     <= adr_n;
      req_q     <= req_n;
      ACK_O     <= (state_d == S_ACK);
      sram_cs_n <= !in_phase;
      sram_oe_n <= !(in_phase && strb_d && !req_n.we);
      sram_we_n <= !(wr_stb && (|sel_pair));
      sram_d_oe <= wr_stb;
      {sram_ub_n, sram_lb_n} <= in_phase ? lane_n : 2'b11;
      // Address and data hold through ACK/IDLE so nothing moves after the last strobe.
      if (in_phase) begin
        sram_a   <= {adr_n, phase_hi};
        sram_d_o <= phase_hi ? req_n.dat[31:16] : req_n.dat[15:0];
      end
      if (CYC_I && strb_q && cnt_last && !req_q.we) begin
        if (state_q == S_LO) DAT_O[15:0]  <= sram_d_i;
        if (state_q == S_HI) DAT_O[31:16] <= sram_d_i;
      end
    end
  end

endmodule

// File: tb/tb_m_sram16_wbctrl.sv
// Scoreboard bench: two controllers (WAITSTATES 0 and 1) on a shared behavioural SRAM array.
module tb_m_sram16_wbctrl;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] dat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc [2], stb [2], we_i [2];
  logic [15:0] adr_i [2];
  logic [3:0]  sel_i [2];
  logic [31:0] dat_i [2], dat_o [2];
  logic        ack [2];
  logic [16:0] sram_a [2];
  logic [15:0] d_o [2], d_in [2];
  logic        d_oe [2], cs_n [2], oe_n [2], we_n [2], lb_n [2], ub_n [2];

  logic [15:0] mem [256];
  logic        clr, pl_en;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;

  int          ecnt = 0;
  int          n_vec = 0, n_err = 0;
  int          acc_edge;
  logic [31:0] m_oe, m_we, m_lb, m_ub;
  sb_t         q0 [$], q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    m_sram16_wbctrl #(.SRAMADRWIDTH(16), .WAITSTATES(k)) u_dut (
      .CLK_I(clk), .RST_I(rst_n), .CYC_I(cyc[k]), .STB_I(stb[k]), .WE_I(we_i[k]),
      .ADR_I(adr_i[k]), .SEL_I(sel_i[k]), .DAT_I(dat_i[k]), .DAT_O(dat_o[k]), .ACK_O(ack[k]),
      .sram_a(sram_a[k]), .sram_d_o(d_o[k]), .sram_d_oe(d_oe[k]), .sram_d_i(d_in[k]),
      .sram_cs_n(cs_n[k]), .sram_oe_n(oe_n[k]), .sram_we_n(we_n[k]),
      .sram_lb_n(lb_n[k]), .sram_ub_n(ub_n[k])
    );
    assign d_in[k] = mem[sram_a[k][7:0]];
  end

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (pl_en) mem[pl_a] <= pl_d;
    else for (int k = 0; k < 2; k++)
      if (!cs_n[k] && !we_n[k] && d_oe[k]) begin
        if (!lb_n[k]) mem[sram_a[k][7:0]][7:0]  <= d_o[k][7:0];
        if (!ub_n[k]) mem[sram_a[k][7:0]][15:8] <= d_o[k][15:8];
      end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ACK pops the next expected entry for that controller.
  always @(negedge clk) begin
    sb_t e;
    bit  got;
    if (rst_n) for (int k = 0; k < 2; k++) if (ack[k]) begin
      got = 1'b0;
      if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      chk("ack_expected", 32'(ack[k]), 32'(got));
      if (got) begin
        chk("ack_cycle", ecnt, e.cyc);
        if (e.rd) chk("rd_data", dat_o[k], e.dat);
      end
    end
  end

  task automatic pre(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One bus access; lat is the ACK cycle counted from the accepting edge.
  // stop_cyc != 0 returns at that cycle with CYC_I still high and nothing queued.
  task automatic xact(input int k, input logic we, input logic [15:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int lat, input logic [31:0] exp_dat,
                      input int stop_cyc);
    int e;
    sb_t s;
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we_i[k] = we; adr_i[k] = adr; sel_i[k] = sel; dat_i[k] = dat;
    @(posedge clk); #1;
    e = ecnt; acc_edge = e;
    we_i[k] = ~we; adr_i[k] = ~adr; sel_i[k] = ~sel; dat_i[k] = ~dat;
    if (stop_cyc == 0) begin
      s.cyc = e + lat - 1; s.rd = !we; s.dat = exp_dat;
      if (k == 0) q0.push_back(s); else q1.push_back(s);
    end
    m_oe = '0; m_we = '0; m_lb = '0; m_ub = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c < 32) begin
        m_oe[c] = !oe_n[k]; m_we[c] = !we_n[k]; m_lb[c] = !lb_n[k]; m_ub[c] = !ub_n[k];
      end
      if (stop_cyc != 0 && c == stop_cyc) return;
      if (ack[k]) begin
        cyc[k] = 1'b0; stb[k] = 1'b0;
        return;
      end
    end
    chk("ack_timeout", 32'(ack[k]), 32'd1);
    cyc[k] = 1'b0; stb[k] = 1'b0;
    if (k == 0 && q0.size() > 0) void'(q0.pop_back());
    if (k == 1 && q1.size() > 0) void'(q1.pop_back());
  endtask

  task automatic chk_idle_pins(input string tag, input int k);
    chk(tag, 32'({cs_n[k], oe_n[k], we_n[k], lb_n[k], ub_n[k]}), 32'h1f);
    chk({tag, "_ack"}, 32'(ack[k]), 32'd0);
    chk({tag, "_dat"}, dat_o[k], 32'd0);
  endtask

  initial begin
    int e1;
    rst_n = 1'b0; clr = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we_i[k] = 1'b0;
      adr_i[k] = '0; sel_i[k] = '0; dat_i[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk_idle_pins("rst_pins", k);
      chk("rst_addr", 32'(sram_a[k]), 32'd0);
      chk("rst_dout", 32'({d_oe[k], d_o[k]}), 32'd0);
    end
    clr = 1'b0; rst_n = 1'b1;

    pre(8'h24, 16'hBEEF); pre(8'h25, 16'hDEAD);
    pre(8'h00, 16'h1111); pre(8'h01, 16'h2222);
    pre(8'h02, 16'h3333); pre(8'h03, 16'h4444);

    // Read, W=1
    xact(1, 1'b0, 16'h0012, 4'hF, 32'h0, 7, 32'hDEADBEEF, 0);
    chk("rd_oe_mask", m_oe, 32'h6C);
    chk("rd_lanes", {m_lb[15:0], m_ub[15:0]}, {16'h7E, 16'h7E});

    // Full write, W=0
    xact(0, 1'b1, 16'h0008, 4'hF, 32'h12345678, 5, 32'h0, 0);
    chk("wr_we_mask", m_we, 32'h14);
    chk("wr_lo", 32'(mem[8'h10]), 32'h5678);
    chk("wr_hi", 32'(mem[8'h11]), 32'h1234);

    // Single byte in the high halfword, W=1
`ifdef M_SRAM16_SKIPHALF_EN
    xact(1, 1'b1, 16'h0009, 4'b0100, 32'hAABBCCDD, 4, 32'h0, 0);
    chk("sel4_lb_mask", m_lb, 32'h0E);
    chk("sel4_we_mask", m_we, 32'h0C);
`else
    xact(1, 1'b1, 16'h0009, 4'b0100, 32'hAABBCCDD, 7, 32'h0, 0);
    chk("sel4_lb_mask", m_lb, 32'h70);
    chk("sel4_we_mask", m_we, 32'h60);
`endif
    chk("sel4_ub_mask", m_ub, 32'h0);
    chk("sel4_mem_hi", 32'(mem[8'h13]), 32'h00BB);
    chk("sel4_mem_lo", 32'(mem[8'h12]), 32'h0);

    // Write with no byte selects, W=0
`ifdef M_SRAM16_SKIPHALF_EN
    xact(0, 1'b1, 16'h000A, 4'b0000, 32'hFFFFFFFF, 1, 32'h0, 0);
`else
    xact(0, 1'b1, 16'h000A, 4'b0000, 32'hFFFFFFFF, 5, 32'h0, 0);
`endif
    chk("sel0_we_mask", m_we, 32'h0);
    chk("sel0_mem", {mem[8'h14], mem[8'h15]}, 32'h0);

    // Back-to-back reads, W=0
    xact(0, 1'b0, 16'h0000, 4'hF, 32'h0, 5, 32'h22221111, 0);
    e1 = acc_edge;
    xact(0, 1'b0, 16'h0001, 4'hF, 32'h0, 5, 32'h44443333, 0);
    chk("b2b_gap", acc_edge - e1, 32'd6);

    // Abort a W=1 write by dropping CYC_I in cycle 3
    xact(1, 1'b1, 16'h0020, 4'hF, 32'h0F0F0F0F, 0, 32'h0, 3);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    chk("abort_pins", 32'({cs_n[1], we_n[1], oe_n[1], ack[1]}), 32'hE);
    chk("abort_dat", dat_o[1], 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("abort_hi_untouched", 32'(mem[8'h41]), 32'h0);
    xact(1, 1'b0, 16'h0000, 4'hF, 32'h0, 7, 32'h22221111, 0);

    // Reset for two cycles while in the HI strobe of a read
    xact(1, 1'b0, 16'h0012, 4'hF, 32'h0, 0, 32'h0, 5);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_pins("midrst_pins", 1);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0; rst_n = 1'b1;
    xact(1, 1'b0, 16'h0001, 4'hF, 32'h0, 7, 32'h44443333, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
